// File: rtl/pb_pack.sv
// Shared types and constants for the program loader.
package pb_pack;

  localparam int unsigned LOAD_DR_WIDTH       = 96;
  localparam int unsigned globalAddress_width = 32;
  localparam int unsigned data_width          = 32;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_VERIFY   = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StRwait,
    StCheck
  } loader_state_t;

endpackage

// File: rtl/pb_sync_fifo.sv
// Synchronous FIFO with a show-ahead head entry; pushes while full and pops while empty
// are ignored.
module pb_sync_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointer/count next state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pb_prog_loader.sv
// Queues TAP LOAD_PROGRAM DR updates and writes them to instruction memory, optionally
// reading each word back to verify it. Holds the core halted while loading.
module pb_prog_loader
  import pb_pack::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned VERIFY     = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           load_en_i,
  input  logic                           upd_valid_i,
  input  logic [LOAD_DR_WIDTH-1:0]       upd_data_i,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [globalAddress_width-1:0] mem_addr_o,
  output logic [data_width-1:0]          mem_wdata_o,
  input  logic                           mem_gnt_i,
  input  logic                           mem_rvalid_i,
  input  logic [data_width-1:0]          mem_rdata_i,
  output logic                           core_halt_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic [1:0]                     err_code_o,
  output logic [15:0]                    wr_count_o
);

  loader_state_t            state_q, state_d;
  logic [data_width-1:0]    rdata_q, rdata_d;
  logic                     err_q, err_d;
  logic [1:0]               err_code_q, err_code_d;
  logic [15:0]              wr_count_q, wr_count_d;
  logic                     load_en_q;
  logic                     halt_q, halt_d;
  logic                     done_q, done_d;

  logic                     push_req, pop;
  logic                     fifo_full, fifo_empty;
  logic [LOAD_DR_WIDTH-1:0] head;
  logic [63:0]              head_addr;
  logic [data_width-1:0]    head_data;
  logic                     addr_oor;
  logic                     wr_inc, rng_err, chk_err, ovf_err, load_rise;

  assign push_req  = upd_valid_i & load_en_i;
  assign head_addr = head[63:0];
  assign head_data = head[95:64];
  assign addr_oor  = (head_addr >= 64'(MEM_WORDS));
  assign ovf_err   = push_req & fifo_full;
  assign load_rise = load_en_i & ~load_en_q;

  pb_sync_fifo #(
    .WIDTH (LOAD_DR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_req),
    .wdata_i (upd_data_i),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Request fields come straight from the held head entry, so they are stable until gnt.
  assign mem_addr_o  = head_addr[globalAddress_width-1:0];
  assign mem_wdata_o = head_data;

  // FSM next state and memory request; the head is popped only once its entry completes.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    pop       = 1'b0;
    wr_inc    = 1'b0;
    rng_err   = 1'b0;
    chk_err   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          if (addr_oor) begin
            pop     = 1'b1;
            rng_err = 1'b1;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_gnt_i) begin
          wr_inc = 1'b1;
          if (VERIFY != 0) begin
            state_d = StRead;
          end else begin
            pop     = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRead: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = StRwait;
      end
      // Read data is expected no earlier than the cycle after the read grant.
      StRwait: begin
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          state_d = StCheck;
        end
      end
      StCheck: begin
        pop     = 1'b1;
        chk_err = (rdata_q != head_data);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky first-error capture, write counter and halt/done generation.
  always_comb begin
    err_d      = err_q;
    err_code_d = err_code_q;
    wr_count_d = wr_count_q;
    if (load_rise) begin
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
      wr_count_d = '0;
    end
    if (!err_d) begin
      if (ovf_err) begin
        err_d      = 1'b1;
        err_code_d = ERR_OVERFLOW;
      end else if (rng_err) begin
        err_d      = 1'b1;
        err_code_d = ERR_RANGE;
      end else if (chk_err) begin
        err_d      = 1'b1;
        err_code_d = ERR_VERIFY;
      end
    end
    if (wr_inc && (wr_count_d != 16'hFFFF)) wr_count_d = wr_count_d + 16'd1;
    halt_d = load_en_i | busy_o;
    done_d = halt_q & ~halt_d;
  end

  assign busy_o = ~fifo_empty | (state_q != StIdle);

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      wr_count_q <= '0;
      load_en_q  <= 1'b0;
      halt_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      wr_count_q <= wr_count_d;
      load_en_q  <= load_en_i;
      halt_q     <= halt_d;
      done_q     <= done_d;
    end
  end

  assign core_halt_o = halt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_pb_prog_loader.sv
// Directed bench for pb_prog_loader with a behavioural instruction memory.
module tb_pb_prog_loader;

  logic        clk = 1'b0;
  logic        rst, load_en, upd_valid;
  logic [95:0] upd_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        core_halt, busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  pb_prog_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_en_i    (load_en),
    .upd_valid_i  (upd_valid),
    .upd_data_i   (upd_data),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .core_halt_o  (core_halt),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .err_code_o   (err_code),
    .wr_count_o   (wr_count)
  );

  // Memory model: grant after gnt_delay request cycles, read data one cycle after grant.
  logic [31:0] mem [1024];
  logic [31:0] wr_addr_log [256];
  logic [31:0] wr_data_log [256];
  logic        rvalid_q = 1'b0;
  logic [31:0] rdata_q = '0;
  logic        gnt_en, blk_rd, corrupt, rv_force;
  int          gnt_delay = 0;
  int          req_wait = 0;
  int          req_cycles = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  assign mem_gnt    = mem_req & gnt_en & (req_wait >= gnt_delay) & ~(blk_rd & ~mem_we);
  assign mem_rvalid = rvalid_q | rv_force;
  assign mem_rdata  = rdata_q;

  always @(posedge clk) begin
    rvalid_q <= 1'b0;
    if (mem_req) req_cycles <= req_cycles + 1;
    if (mem_req && !mem_gnt) req_wait <= req_wait + 1;
    else req_wait <= 0;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        mem[mem_addr[9:0]]  <= mem_wdata;
        wr_addr_log[wr_cnt] <= mem_addr;
        wr_data_log[wr_cnt] <= mem_wdata;
        wr_cnt              <= wr_cnt + 1;
      end else begin
        rvalid_q <= 1'b1;
        rdata_q  <= corrupt ? 32'hDEADBEEF : mem[mem_addr[9:0]];
        rd_cnt   <= rd_cnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] addr, input logic [31:0] data);
    upd_valid = 1'b1;
    upd_data  = {data, addr};
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic reload();
    load_en = 1'b0;
    tick();
    load_en = 1'b1;
    tick();
  endtask

  int wr_base;
  int rd_base;
  int req_base;
  int n;

  initial begin
    rst       = 1'b1;
    load_en   = 1'b0;
    upd_valid = 1'b0;
    upd_data  = '0;
    gnt_en    = 1'b1;
    blk_rd    = 1'b0;
    corrupt   = 1'b0;
    rv_force  = 1'b0;
    tick();
    tick();
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    check("rst_halt", 64'(core_halt), 64'd1);
    load_en = 1'b1;
    tick();
    rst = 1'b0;
    check("halt_first_cycle", 64'(core_halt), 64'd1);
    tick();

    // Single word, echoing memory, exact latency.
    wr_base = wr_cnt;
    rd_base = rd_cnt;
    push(64'd0, 32'h00500113);
    check("t1_no_req_n1", 64'(mem_req), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_req_n2", 64'(mem_req), 64'd1);
    check("t1_we", 64'(mem_we), 64'd1);
    check("t1_addr", 64'(mem_addr), 64'd0);
    check("t1_wdata", 64'(mem_wdata), 64'h00500113);
    wait_idle(50, "t1_idle");
    check("t1_writes", 64'(wr_cnt - wr_base), 64'd1);
    check("t1_reads", 64'(rd_cnt - rd_base), 64'd1);
    check("t1_wr_count", 64'(wr_count), 64'd1);
    check("t1_err", 64'(err), 64'd0);
    check("t1_halt_held", 64'(core_halt), 64'd1);
    load_en = 1'b0;
    tick();
    check("t1_done_pulse", 64'(done), 64'd1);
    check("t1_halt_low", 64'(core_halt), 64'd0);
    tick();
    check("t1_done_once", 64'(done), 64'd0);

    // 56 spaced pushes with a 3-cycle grant delay.
    load_en   = 1'b1;
    gnt_delay = 3;
    wr_base   = wr_cnt;
    tick();
    check("t2_count_clr", 64'(wr_count), 64'd0);
    for (int i = 0; i < 56; i++) begin
      push(64'(i), 32'hA000_0000 + 32'(i));
      repeat (99) tick();
    end
    wait_idle(200, "t2_idle");
    check("t2_writes", 64'(wr_cnt - wr_base), 64'd56);
    for (int i = 0; i < 56; i++) begin
      check("t2_addr_order", 64'(wr_addr_log[wr_base + i]), 64'(i));
      check("t2_data_order", 64'(wr_data_log[wr_base + i]), 64'(32'hA000_0000 + 32'(i)));
    end
    check("t2_wr_count", 64'(wr_count), 64'd56);
    check("t2_err", 64'(err), 64'd0);

    // Overflow: five back-to-back pushes with no grant.
    reload();
    gnt_en    = 1'b0;
    gnt_delay = 0;
    wr_base   = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      upd_valid = 1'b1;
      upd_data  = {32'hB000_0000 + 32'(i), 64'd100 + 64'(i)};
      tick();
    end
    upd_valid = 1'b0;
    check("t3_ovf_err", 64'(err), 64'd1);
    check("t3_ovf_code", 64'(err_code), 64'h1);
    gnt_en = 1'b1;
    wait_idle(100, "t3_idle");
    check("t3_writes", 64'(wr_cnt - wr_base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("t3_addr", 64'(wr_addr_log[wr_base + i]), 64'd100 + 64'(i));
    end
    check("t3_wr_count", 64'(wr_count), 64'd4);
    check("t3_code_sticky", 64'(err_code), 64'h1);

    // Out-of-range address.
    reload();
    check("t4_err_clr", 64'(err), 64'd0);
    check("t4_count_clr", 64'(wr_count), 64'd0);
    push(64'd3, 32'h11);
    wait_idle(50, "t4_idle_a");
    check("t4_wr_count_a", 64'(wr_count), 64'd1);
    req_base = req_cycles;
    push(64'h1_0000_0000, 32'h22);
    wait_idle(20, "t4_idle_b");
    check("t4_no_req", 64'(req_cycles - req_base), 64'd0);
    check("t4_err", 64'(err), 64'd1);
    check("t4_code", 64'(err_code), 64'h2);
    check("t4_wr_count_b", 64'(wr_count), 64'd1);

    // Verify mismatch.
    reload();
    corrupt = 1'b1;
    push(64'd5, 32'h12345678);
    wait_idle(50, "t5_popped");
    check("t5_err", 64'(err), 64'd1);
    check("t5_code", 64'(err_code), 64'h3);
    check("t5_wr_count", 64'(wr_count), 64'd1);
    corrupt = 1'b0;

    // Reset while in READ, then a stray rvalid.
    reload();
    blk_rd = 1'b1;
    push(64'd7, 32'h77);
    push(64'd8, 32'h88);
    n = 0;
    while (!(mem_req === 1'b1 && mem_we === 1'b0) && n < 20) begin
      tick();
      n++;
    end
    check("t6_in_read", 64'(mem_req & ~mem_we), 64'd1);
    rst = 1'b1;
    tick();
    check("t6_req", 64'(mem_req), 64'd0);
    check("t6_fifo_empty", 64'(busy), 64'd0);
    check("t6_halt", 64'(core_halt), 64'd1);
    check("t6_wr_count", 64'(wr_count), 64'd0);
    rst      = 1'b0;
    rv_force = 1'b1;
    tick();
    rv_force = 1'b0;
    tick();
    check("t6_late_rvalid_req", 64'(mem_req), 64'd0);
    check("t6_late_rvalid_busy", 64'(busy), 64'd0);
    check("t6_late_rvalid_err", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_prog_loader.md
PB_PROG_LOADER -- requirements
Module: pb_prog_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered DR updates (power of two, >=2).
REQ-002 SHALL have parameter MEM_WORDS, default 1024, meaning the number of valid instruction-memory words.
REQ-003 SHALL have parameter VERIFY, default 1, meaning read back and compare each write when 1.
REQ-004 SHALL have port clk_i, input, 1, the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port load_en_i, input, 1, high while the TAP IR holds LOAD_PROGRAM.
REQ-007 SHALL have port upd_valid_i, input, 1, one-cycle pulse on each completed UPDATE_DR.
REQ-008 SHALL have port upd_data_i, input, 96, with [63:0] the word address and [95:64] the instruction.
REQ-009 SHALL have ports mem_req_o (1), mem_we_o (1), mem_addr_o (globalAddress_width) and mem_wdata_o (data_width), all outputs, forming the memory request.
REQ-010 SHALL have ports mem_gnt_i (1), mem_rvalid_i (1) and mem_rdata_i (data_width), all inputs, forming the memory response.
REQ-011 SHALL have port core_halt_o, output, 1, which holds the core in reset/stall while loading.
REQ-012 SHALL have ports busy_o (1), done_o (1), err_o (1), err_code_o (2) and wr_count_o (16), all outputs, providing status.

Function
REQ-013 SHALL push {addr, data} into the FIFO on upd_valid_i && load_en_i; upd_valid_i while load_en_i is low is ignored.
REQ-014 SHALL drop a push when the FIFO is full, set err_o and set err_code_o=2'b01 (overflow).
REQ-015 SHALL use FSM states IDLE, WRITE, READ, RWAIT and CHECK.
REQ-016 IDLE SHALL go to WRITE when the FIFO is non-empty; the head entry is held, not popped, until it completes.
REQ-017 In IDLE, if the head address >= MEM_WORDS, the FSM SHALL pop without a memory access, set err_o and set err_code_o=2'b10 (range), and stay in IDLE.
REQ-018 WRITE SHALL assert mem_req_o=1 and mem_we_o=1, and drive mem_addr_o with the head address low bits and mem_wdata_o with the head data, stable until mem_gnt_i.
REQ-019 On gnt in WRITE, the FSM SHALL increment wr_count_o (saturating at 16'hFFFF), then go to READ if VERIFY=1; otherwise it SHALL pop and go to IDLE.
REQ-020 READ SHALL assert mem_req_o=1 and mem_we_o=0 with the same address until gnt, then go to RWAIT.
REQ-021 RWAIT SHALL wait for mem_rvalid_i, capture mem_rdata_i, and go to CHECK.
REQ-022 CHECK SHALL compare the captured data with the head data; on mismatch it SHALL set err_o and err_code_o=2'b11. It SHALL always pop and go to IDLE.
REQ-023 mem_req_o SHALL be 0 in IDLE, RWAIT and CHECK, and no request SHALL be issued without a registered FSM state.
REQ-024 A simultaneous push and pop SHALL leave the FIFO count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 err_o and err_code_o SHALL be sticky and hold the first error; they SHALL clear only on reset or on a load_en_i rising edge.
REQ-026 wr_count_o SHALL clear on a load_en_i rising edge.
REQ-027 busy_o SHALL be 1 when the FIFO is non-empty or the FSM is not IDLE.
REQ-028 core_halt_o SHALL be registered and equal load_en_i | busy_o from the previous cycle.
REQ-029 done_o SHALL pulse for one cycle on the cycle core_halt_o falls.
REQ-030 If load_en_i falls while busy, the block SHALL drain the queued entries before releasing halt.
REQ-031 Minimum latency SHALL be: push at cycle N leads to mem_req_o at N+2 with a FIFO-empty IDLE and gnt in the same cycle.

Reset
REQ-032 While rst_i is high at a clk_i edge, the FSM SHALL go to IDLE, the FIFO SHALL empty, and mem_req_o, mem_we_o, busy_o, done_o, err_o, err_code_o and wr_count_o SHALL be 0.
REQ-033 core_halt_o SHALL be 1 during reset and for the first cycle after reset.
REQ-034 Reset during WRITE/READ SHALL abandon the transaction, and a late mem_rvalid_i SHALL be ignored.

Structure
REQ-035 pb_pack SHALL hold the state enum loader_state_t, the err code constants, the LOAD_DR_WIDTH=96 constant, and globalAddress_width and data_width.
REQ-036 The FIFO SHALL be one sub-module, pb_sync_fifo (parameterised WIDTH and DEPTH, with full/empty flags).

Verification
REQ-037 Load_en=1, push addr 0 with data 32'h00500113, gnt always 1 with echoing memory -> exactly one write to addr 0, one read, wr_count=1, err_o=0, then done_o pulse after load_en falls.
REQ-038 56 back-to-back pushes with gnt delayed 3 cycles and FIFO_DEPTH=4, each push spaced by 100 TAP-like cycles -> all 56 words written in order, err_o=0.
REQ-039 5 pushes in 5 consecutive cycles with gnt held 0 -> 5th dropped, err_code=01, first 4 written once gnt is released.
REQ-040 Push addr 64'h1_0000_0000 -> no mem_req_o, err_code=10, wr_count unchanged.
REQ-041 Memory model returns 32'hDEADBEEF on readback -> err_code=11, entry still popped.
REQ-042 Assert rst_i while in READ -> next cycle mem_req_o=0, FIFO empty, core_halt_o=1; a subsequent rvalid pulse causes no state change.
